// File: rtl/ram_1w_1rs_arbiter_pkg.sv
// ============================================================================
// Module      : ram_1w_1rs_arbiter_pkg
// Description : Shared sizing helpers for the 1W/1R RAM port arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ram_1w_1rs_arbiter_pkg;

    localparam int unsigned c_MIN_PTR_W = 1;

    // Round-robin pointer width; a single port still needs a 1-bit register.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : int'(c_MIN_PTR_W);
    endfunction

    function automatic int lane_width(input int data_w, input int mask_w);
        return data_w / mask_w;
    endfunction

    // Low bit of field idx inside a packed bus of w-bit fields.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_1w_1rs_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin picker: first asserted request at or after ptr_i.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import ram_1w_1rs_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o
);

    logic w_found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        if (en_i) begin
            for (int k = 0; k < N; k++) begin
                if (!w_found && req_i[(int'(ptr_i) + k) % N]) begin
                    w_found                         = 1'b1;
                    grant_o[(int'(ptr_i) + k) % N]  = 1'b1;
                    idx_o                           = PW'((int'(ptr_i) + k) % N);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_1w_1rs_arbiter.sv
// ============================================================================
// Module      : ram_1w_1rs_arbiter
// Description : Shares one 1W/1R RAM between several write and read requesters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ram_1w_1rs_arbiter
    import ram_1w_1rs_arbiter_pkg::*;
#(
    parameter int WR_PORTS     = 2,
    parameter int RD_PORTS     = 2,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = 4,
    parameter int HAZARD_STALL = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [WR_PORTS-1:0]            wr_req_valid,
    output logic [WR_PORTS-1:0]            wr_req_ready,
    input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_req_data,
    input  logic [WR_PORTS*MASK_WIDTH-1:0] wr_req_mask,
    input  logic [RD_PORTS-1:0]            rd_req_valid,
    output logic [RD_PORTS-1:0]            rd_req_ready,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_req_addr,
    output logic [RD_PORTS-1:0]            rd_rsp_valid,
    output logic [DATA_WIDTH-1:0]          rd_rsp_data,
    output logic                           ram_wr_en,
    output logic [MASK_WIDTH-1:0]          ram_wr_mask,
    output logic [ADDR_WIDTH-1:0]          ram_wr_addr,
    output logic [DATA_WIDTH-1:0]          ram_wr_data,
    output logic                           ram_rd_en,
    output logic [ADDR_WIDTH-1:0]          ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]          ram_rd_data
);

    localparam int WPW = ptr_width(WR_PORTS);
    localparam int RPW = ptr_width(RD_PORTS);

    logic [WPW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [RPW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [RD_PORTS-1:0] rsp_port_q, rsp_port_d;

    logic [WR_PORTS-1:0]   w_wr_grant;
    logic [WPW-1:0]        w_wr_idx;
    logic [RD_PORTS-1:0]   w_rd_cand;
    logic [RPW-1:0]        w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_hazard;

    rr_arbiter #(
        .N  (WR_PORTS),
        .PW (WPW)
    ) u_wr_arb (
        .req_i   (wr_req_valid),
        .ptr_i   (wr_ptr_q),
        .en_i    (!reset),
        .grant_o (w_wr_grant),
        .idx_o   (w_wr_idx)
    );

    rr_arbiter #(
        .N  (RD_PORTS),
        .PW (RPW)
    ) u_rd_arb (
        .req_i   (rd_req_valid),
        .ptr_i   (rd_ptr_q),
        .en_i    (!reset),
        .grant_o (w_rd_cand),
        .idx_o   (w_rd_idx)
    );

    assign wr_req_ready = w_wr_grant;
    assign ram_wr_en    = |w_wr_grant;
    assign ram_wr_addr  = wr_req_addr[slice_lo(int'(w_wr_idx), ADDR_WIDTH) +: ADDR_WIDTH];
    assign ram_wr_data  = wr_req_data[slice_lo(int'(w_wr_idx), DATA_WIDTH) +: DATA_WIDTH];
    assign ram_wr_mask  = wr_req_mask[slice_lo(int'(w_wr_idx), MASK_WIDTH) +: MASK_WIDTH];

    // Holding the colliding read one cycle makes it observe the freshly written word.
    assign w_rd_addr    = rd_req_addr[slice_lo(int'(w_rd_idx), ADDR_WIDTH) +: ADDR_WIDTH];
    assign w_hazard     = (HAZARD_STALL != 0) && ram_wr_en && (|w_rd_cand)
                          && (w_rd_addr == ram_wr_addr);
    assign rd_req_ready = w_hazard ? '0 : w_rd_cand;
    assign ram_rd_en    = |rd_req_ready;
    assign ram_rd_addr  = w_rd_addr;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rsp_port_d = '0;
        if (ram_wr_en) begin
            wr_ptr_d = WPW'((int'(w_wr_idx) + 1) % WR_PORTS);
        end
        if (ram_rd_en) begin
            rd_ptr_d   = RPW'((int'(w_rd_idx) + 1) % RD_PORTS);
            rsp_port_d = rd_req_ready;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rsp_port_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rsp_port_q <= rsp_port_d;
        end
    end

    assign rd_rsp_valid = rsp_port_q;
    assign rd_rsp_data  = ram_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_ram_1w_1rs_arbiter.sv
// ============================================================================
// Module      : tb_ram_1w_1rs_arbiter
// Description : Random and directed checks of the RAM arbiter against a model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_1w_1rs_arbiter;

    localparam int WRP = 2;
    localparam int RDP = 2;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int MW  = 4;
    localparam int LW  = DW / MW;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [WRP-1:0]    wr_req_valid = '0;
    logic [WRP*AW-1:0] wr_req_addr  = '0;
    logic [WRP*DW-1:0] wr_req_data  = '0;
    logic [WRP*MW-1:0] wr_req_mask  = '0;
    logic [RDP-1:0]    rd_req_valid = '0;
    logic [RDP*AW-1:0] rd_req_addr  = '0;

    logic [WRP-1:0] wr_req_ready, nh_wr_req_ready;
    logic [RDP-1:0] rd_req_ready, nh_rd_req_ready;
    logic [RDP-1:0] rd_rsp_valid, nh_rd_rsp_valid;
    logic [DW-1:0]  rd_rsp_data, nh_rd_rsp_data;
    logic           ram_wr_en, nh_ram_wr_en;
    logic [MW-1:0]  ram_wr_mask, nh_ram_wr_mask;
    logic [AW-1:0]  ram_wr_addr, nh_ram_wr_addr;
    logic [DW-1:0]  ram_wr_data, nh_ram_wr_data;
    logic           ram_rd_en, nh_ram_rd_en;
    logic [AW-1:0]  ram_rd_addr, nh_ram_rd_addr;
    logic [DW-1:0]  ram_rd_data = '0;

    ram_1w_1rs_arbiter #(
        .WR_PORTS(WRP), .RD_PORTS(RDP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MASK_WIDTH(MW), .HAZARD_STALL(1)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_mask(wr_req_mask),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .ram_wr_en(ram_wr_en), .ram_wr_mask(ram_wr_mask), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data)
    );

    // Same stimulus with the hazard stall disabled; only its grants are observed.
    ram_1w_1rs_arbiter #(
        .WR_PORTS(WRP), .RD_PORTS(RDP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MASK_WIDTH(MW), .HAZARD_STALL(0)
    ) dut_nh (
        .clk(clk), .reset(reset),
        .wr_req_valid(wr_req_valid), .wr_req_ready(nh_wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_mask(wr_req_mask),
        .rd_req_valid(rd_req_valid), .rd_req_ready(nh_rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(nh_rd_rsp_valid), .rd_rsp_data(nh_rd_rsp_data),
        .ram_wr_en(nh_ram_wr_en), .ram_wr_mask(nh_ram_wr_mask), .ram_wr_addr(nh_ram_wr_addr),
        .ram_wr_data(nh_ram_wr_data), .ram_rd_en(nh_ram_rd_en), .ram_rd_addr(nh_ram_rd_addr),
        .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with a registered read port.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;

    always @(posedge clk) begin
        if (ram_wr_en)
            for (int l = 0; l < MW; l++)
                if (ram_wr_mask[l]) ram_mem[ram_wr_addr][l*LW +: LW] <= ram_wr_data[l*LW +: LW];
        if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_wr_ptr, m_rd_ptr, m_rd_ptr_nh;
    logic [RDP-1:0] m_rsp_port;
    logic [DW-1:0]  m_rsp_data;
    int            e_ww, e_rc, e_rc_nh;
    logic          e_rgnt;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [DW-1:0] e_wdata;
    logic [MW-1:0] e_wmask;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input logic [1:0] v, input int p, input int n);
        for (int k = 0; k < n; k++)
            if (v[(p + k) % n]) return (p + k) % n;
        return -1;
    endfunction

    task automatic model_reset();
        m_wr_ptr    = 0;
        m_rd_ptr    = 0;
        m_rd_ptr_nh = 0;
        m_rsp_port  = '0;
        m_rsp_data  = '0;
    endtask

    // Called shortly after a rising edge; evaluates expectations mid-cycle.
    task automatic step();
        logic [WRP-1:0] exp_wr;
        logic [RDP-1:0] exp_rd, exp_rd_nh;
        #3;
        e_ww    = rr_pick(wr_req_valid, m_wr_ptr, WRP);
        e_rc    = rr_pick(rd_req_valid, m_rd_ptr, RDP);
        e_rc_nh = rr_pick(rd_req_valid, m_rd_ptr_nh, RDP);
        e_waddr = (e_ww >= 0) ? wr_req_addr[e_ww*AW +: AW] : '0;
        e_wdata = (e_ww >= 0) ? wr_req_data[e_ww*DW +: DW] : '0;
        e_wmask = (e_ww >= 0) ? wr_req_mask[e_ww*MW +: MW] : '0;
        e_raddr = (e_rc >= 0) ? rd_req_addr[e_rc*AW +: AW] : '0;
        e_rgnt  = (e_rc >= 0) && !((e_ww >= 0) && (e_raddr == e_waddr));
        exp_wr    = (e_ww >= 0) ? WRP'(1 << e_ww) : '0;
        exp_rd    = e_rgnt ? RDP'(1 << e_rc) : '0;
        exp_rd_nh = (e_rc_nh >= 0) ? RDP'(1 << e_rc_nh) : '0;
        chk("wr_ready", wr_req_ready, exp_wr);
        chk("nh_wr_ready", nh_wr_req_ready, exp_wr);
        chk("ram_wr_en", ram_wr_en, e_ww >= 0);
        if (e_ww >= 0) begin
            chk("ram_wr_addr", ram_wr_addr, e_waddr);
            chk("ram_wr_data", ram_wr_data, e_wdata);
            chk("ram_wr_mask", ram_wr_mask, e_wmask);
        end
        chk("rd_ready", rd_req_ready, exp_rd);
        chk("nh_rd_ready", nh_rd_req_ready, exp_rd_nh);
        chk("ram_rd_en", ram_rd_en, e_rgnt);
        if (e_rgnt) chk("ram_rd_addr", ram_rd_addr, e_raddr);
        chk("rsp_valid", rd_rsp_valid, m_rsp_port);
        if (m_rsp_port != '0) chk("rsp_data", rd_rsp_data, m_rsp_data);
    endtask

    task automatic tick();
        if (e_rgnt) begin
            m_rsp_port = RDP'(1 << e_rc);
            m_rsp_data = ref_mem[e_raddr];
            m_rd_ptr   = (e_rc + 1) % RDP;
        end else begin
            m_rsp_port = '0;
        end
        if (e_rc_nh >= 0) m_rd_ptr_nh = (e_rc_nh + 1) % RDP;
        if (e_ww >= 0) begin
            for (int l = 0; l < MW; l++)
                if (e_wmask[l]) ref_mem[e_waddr][l*LW +: LW] = e_wdata[l*LW +: LW];
            m_wr_ptr = (e_ww + 1) % WRP;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_req_valid = '0;
        rd_req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        model_reset();

        wr_req_valid = 2'b11;
        rd_req_valid = 2'b11;
        #2;
        chk("rst_wr_ready", wr_req_ready, 2'b00);
        chk("rst_rd_ready", rd_req_ready, 2'b00);
        chk("rst_ram_wr_en", ram_wr_en, 1'b0);
        chk("rst_rsp_valid", rd_rsp_valid, 2'b00);
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Alternating write grants
        wr_req_valid = 2'b11;
        wr_req_addr  = {8'h20, 8'h10};
        wr_req_data  = {32'h2222_2222, 32'h1111_1111};
        wr_req_mask  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("alt_grant", wr_req_ready, (i % 2) ? 2'b10 : 2'b01);
            chk("alt_addr", ram_wr_addr, (i % 2) ? 8'h20 : 8'h10);
            tick();
        end

        // Write then read back through port 1
        idle();
        wr_req_valid = 2'b01;
        wr_req_addr  = {8'h00, 8'h05};
        wr_req_data  = {32'h0, 32'hDEAD_BEEF};
        wr_req_mask  = {4'h0, 4'hF};
        step(); tick();
        idle();
        rd_req_valid = 2'b10;
        rd_req_addr  = {8'h05, 8'h00};
        step();
        chk("rd1_grant", rd_req_ready, 2'b10);
        tick();
        idle();
        step();
        chk("rd1_rsp_valid", rd_rsp_valid, 2'b10);
        chk("rd1_rsp_data", rd_rsp_data, 32'hDEAD_BEEF);
        tick();

        // Same-cycle write and read of one address
        wr_req_valid = 2'b01;
        wr_req_addr  = {8'h00, 8'h07};
        wr_req_data  = {32'h0, 32'h1234_5678};
        wr_req_mask  = {4'h0, 4'hF};
        rd_req_valid = 2'b01;
        rd_req_addr  = {8'h00, 8'h07};
        step();
        chk("haz_stall", rd_req_ready, 2'b00);
        chk("haz_nh_grant", nh_rd_req_ready, 2'b01);
        tick();
        wr_req_valid = 2'b00;
        step();
        chk("haz_issue", rd_req_ready, 2'b01);
        tick();
        idle();
        step();
        chk("haz_rsp_valid", rd_rsp_valid, 2'b01);
        chk("haz_rsp_data", rd_rsp_data, 32'h1234_5678);
        tick();

        // Partial-lane write over zero
        wr_req_valid = 2'b01;
        wr_req_addr  = {8'h00, 8'h30};
        wr_req_data  = {32'h0, 32'hAABB_CCDD};
        wr_req_mask  = {4'h0, 4'b0010};
        step(); tick();
        idle();
        rd_req_valid = 2'b01;
        rd_req_addr  = {8'h00, 8'h30};
        step(); tick();
        idle();
        step();
        chk("mask_data", rd_rsp_data, 32'h0000_CC00);
        tick();

        // Fairness: lone requester, then contention
        wr_req_addr = {8'h61, 8'h60};
        wr_req_mask = 8'hFF;
        wr_req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fair_solo", wr_req_ready, 2'b01);
            tick();
        end
        wr_req_valid = 2'b11;
        step(); chk("fair_p1_first", wr_req_ready, 2'b10); tick();
        step(); chk("fair_p0_next", wr_req_ready, 2'b01); tick();

        // Reset while a response is in flight
        idle();
        rd_req_valid = 2'b01;
        rd_req_addr  = {8'h00, 8'h05};
        step(); tick();
        chk("pre_rst_rsp", rd_rsp_valid, 2'b01);
        idle();
        reset = 1'b1;
        #1;
        chk("rst_rsp_cleared", rd_rsp_valid, 2'b00);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold_rsp", rd_rsp_valid, 2'b00);
        reset = 1'b0;
        wr_req_valid = 2'b11;
        wr_req_addr  = {8'h41, 8'h40};
        rd_req_valid = 2'b11;
        rd_req_addr  = {8'h51, 8'h50};
        step();
        chk("post_rst_wr", wr_req_ready, 2'b01);
        chk("post_rst_rd", rd_req_ready, 2'b01);
        tick();

        // Randomised traffic on a small address window to provoke hazards
        for (int c = 0; c < 400; c++) begin
            wr_req_valid = 2'($urandom_range(0, 3));
            rd_req_valid = 2'($urandom_range(0, 3));
            for (int p = 0; p < WRP; p++) begin
                wr_req_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
                wr_req_data[p*DW +: DW] = $urandom;
                wr_req_mask[p*MW +: MW] = MW'($urandom_range(0, 15));
            end
            for (int p = 0; p < RDP; p++)
                rd_req_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            step();
            tick();
        end
        idle();
        step();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
